// File: rtl/edge_grey_pipe_if.sv
// -----------------------------------------------------------------------------
// edge_grey_pipe_if
// Streaming handshake bundle for edge_grey_pipe.
//   data_in/sop_in/eop_in/valid_in : RGB888 sink beat from upstream
//   ready_out                      : sink back-pressure to upstream
//   data_out/sop_out/eop_out/valid_out : 8-bit luma source beat
//   ready_in                       : source back-pressure from downstream
// master : the side that feeds pixels in and drains luma out
// slave  : the converter itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface edge_grey_pipe_if;
    logic [23:0] data_in;
    logic        sop_in;
    logic        eop_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        sop_out;
    logic        eop_out;
    logic        valid_out;
    logic        ready_in;

    modport master (
        output data_in, sop_in, eop_in, valid_in, ready_in,
        input  ready_out, data_out, sop_out, eop_out, valid_out
    );

    modport slave (
        input  data_in, sop_in, eop_in, valid_in, ready_in,
        output ready_out, data_out, sop_out, eop_out, valid_out
    );
endinterface

// File: rtl/edge_grey_pipe.sv
// -----------------------------------------------------------------------------
// edge_grey_pipe
// Two-stage RGB888 -> 8-bit luma converter with Avalon-ST style handshake and
// frame-structure checking on the input side.
//   clock_clk : sole clock, rising edge
//   reset_n   : asynchronous active-low reset
//   st        : handshake bundle (slave modport), see edge_grey_pipe_if
//   frame_err : sticky framing-error flag
//   frame_cnt : count of accepted eop beats, wraps at 16 bits
// Y = (77*R + 150*G + 29*B) >> 8, truncated; the sum never exceeds 16 bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module edge_grey_pipe #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clock_clk,
    input  logic             reset_n,
    edge_grey_pipe_if.slave  st,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    // Holds ready_out low until the first clock edge after reset release.
    logic        r_rst_done;

    logic        r_s1_valid;
    logic [15:0] r_s1_pr;
    logic [15:0] r_s1_pg;
    logic [15:0] r_s1_pb;
    logic        r_s1_sop;
    logic        r_s1_eop;

    logic        r_s2_valid;
    logic [7:0]  r_s2_y;
    logic        r_s2_sop;
    logic        r_s2_eop;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_in_frame;
    logic          r_frame_err;
    logic [15:0]   r_frame_cnt;

    logic          w_s2_ld;
    logic          w_s1_ld;
    logic          w_acc;
    logic [15:0]   w_sum;
    logic [XW-1:0] w_px;
    logic [YW-1:0] w_py;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic          w_at_origin;
    logic          w_at_last;
    logic          w_err;

    // A stage may load when it is empty or its content leaves this cycle.
    assign w_s2_ld      = !r_s2_valid || st.ready_in;
    assign w_s1_ld      = !r_s1_valid || w_s2_ld;
    assign st.ready_out = r_rst_done && w_s1_ld;
    assign w_acc        = st.valid_in && st.ready_out;

    assign w_sum = r_s1_pr + r_s1_pg + r_s1_pb;

    always_ff @(posedge clock_clk or negedge reset_n) begin
        if (!reset_n) r_rst_done <= 1'b0;
        else          r_rst_done <= 1'b1;
    end

    always_ff @(posedge clock_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_pr    <= '0;
            r_s1_pg    <= '0;
            r_s1_pb    <= '0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
        end else if (w_s1_ld) begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_pr  <= 16'd77  * {8'd0, st.data_in[23:16]};
                r_s1_pg  <= 16'd150 * {8'd0, st.data_in[15:8]};
                r_s1_pb  <= 16'd29  * {8'd0, st.data_in[7:0]};
                r_s1_sop <= st.sop_in;
                r_s1_eop <= st.eop_in;
            end
        end
    end

    always_ff @(posedge clock_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_sop   <= 1'b0;
            r_s2_eop   <= 1'b0;
        end else if (w_s2_ld) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y   <= w_sum[15:8];
                r_s2_sop <= r_s1_sop;
                r_s2_eop <= r_s1_eop;
            end
        end
    end

    assign st.valid_out = r_s2_valid;
    assign st.data_out  = r_s2_y;
    assign st.sop_out   = r_s2_sop;
    assign st.eop_out   = r_s2_eop;

    // Position of the beat being accepted: a sop beat is always (0,0).
    always_comb begin
        w_px        = st.sop_in ? '0 : r_x;
        w_py        = st.sop_in ? '0 : r_y;
        w_at_origin = (w_px == '0) && (w_py == '0);
        w_at_last   = (w_px == X_LAST) && (w_py == Y_LAST);
        w_err       = (st.sop_in && r_in_frame && !((r_x == '0) && (r_y == '0)))
                   || (st.eop_in && !w_at_last)
                   || (!st.sop_in && !r_in_frame && w_at_origin);
        w_x_nxt = '0;
        w_y_nxt = '0;
        if (!st.eop_in) begin
            if (w_px == X_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (w_py == Y_LAST) ? '0 : w_py + 1'b1;
            end else begin
                w_x_nxt = w_px + 1'b1;
                w_y_nxt = w_py;
            end
        end
    end

    always_ff @(posedge clock_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_in_frame  <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_acc) begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_in_frame <= !st.eop_in && (st.sop_in || r_in_frame);
            if (w_err)
                r_frame_err <= 1'b1;
            if (st.eop_in)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_edge_grey_pipe.sv
`timescale 1ns/1ps
module tb_edge_grey_pipe;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    edge_grey_pipe_if bus ();

    edge_grey_pipe #(.IMG_W(W), .IMG_H(H)) dut (
        .clock_clk (clk),
        .reset_n   (rst_n),
        .st        (bus),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
    bit          gap_en   = 1'b0;
    logic [9:0]  exp_q[$];       // {luma, sop, eop}
    int          m_pos    = 0;   // linear pixel index within the frame
    bit          m_inframe = 1'b0;
    bit          m_err    = 1'b0;
    logic [15:0] m_cnt    = '0;
    bit          hold_v   = 1'b0;
    logic [9:0]  hold_d   = '0;

    function automatic logic [7:0] luma(input logic [23:0] d);
        int s;
        s = 77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0]);
        return 8'(s / 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame rules applied to a linear pixel index.
    task automatic model_accept(input logic [23:0] d, input bit s, input bit e);
        exp_q.push_back({luma(d), s, e});
        if (s) begin
            if (m_inframe && m_pos != 0) m_err = 1'b1;
            m_pos     = 0;
            m_inframe = 1'b1;
        end else if (!m_inframe && m_pos == 0) begin
            m_err = 1'b1;
        end
        if (e) begin
            if (m_pos != NPIX - 1) m_err = 1'b1;
            m_cnt     = m_cnt + 16'd1;
            m_pos     = 0;
            m_inframe = 1'b0;
        end else begin
            m_pos = (m_pos + 1) % NPIX;
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] got;
        got = {bus.data_out, bus.sop_out, bus.eop_out};
        if (hold_v)
            check("stall_hold", {21'd0, bus.valid_out, got}, {21'd0, 1'b1, hold_d});
        hold_v = bus.valid_out && !bus.ready_in;
        hold_d = got;
        if (bus.valid_out && bus.ready_in) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL spurious_out: observed beat 0x%0h expected none", got);
            end else begin
                check("out_beat", {22'd0, got}, {22'd0, exp_q.pop_front()});
            end
        end
        if (bus.valid_in && bus.ready_out && rst_n)
            model_accept(bus.data_in, bus.sop_in, bus.eop_in);
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.ready_in = 1'b1;
            1:       bus.ready_in = 1'($urandom_range(1, 0));
            default: bus.ready_in = 1'b0;
        endcase
    endtask

    task automatic send_beat(input logic [23:0] d, input bit s, input bit e);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (gap_en && $urandom_range(1, 0) == 1) begin
            bus.valid_in = 1'b0;
            step();
        end
        bus.data_in  = d;
        bus.sop_in   = s;
        bus.eop_in   = e;
        bus.valid_in = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.ready_out;
            step();
            guard++;
        end while (!acc && guard < 300);
        if (!acc) begin
            n_assert++;
            n_fail++;
            $error("FAIL send_timeout: observed ready_out 0 for %0d cycles expected acceptance", guard);
        end
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        bus.eop_in   = 1'b0;
    endtask

    task automatic send_pixels(input int first, input int last, input int eop_at);
        for (int i = first; i <= last; i++)
            send_beat(24'($urandom), i == 0, i == eop_at);
    endtask

    task automatic drain();
        int g;
        g = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || bus.valid_out) && g < 300) begin
            step();
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_counters(input string tag, input bit err, input logic [15:0] cnt);
        check({tag, "_err_model"}, {31'd0, frame_err}, {31'd0, m_err});
        check({tag, "_cnt_model"}, {16'd0, frame_cnt}, {16'd0, m_cnt});
        check({tag, "_err"}, {31'd0, frame_err}, {31'd0, err});
        check({tag, "_cnt"}, {16'd0, frame_cnt}, {16'd0, cnt});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_pos     = 0;
        m_inframe = 1'b0;
        m_err     = 1'b0;
        m_cnt     = '0;
        hold_v    = 1'b0;
        #1;
        check("rst_valid_out", {31'd0, bus.valid_out}, 0);
        check("rst_data_out", {24'd0, bus.data_out}, 0);
        check("rst_sop_eop", {30'd0, bus.sop_out, bus.eop_out}, 0);
        check("rst_ready_out", {31'd0, bus.ready_out}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", {31'd0, bus.ready_out}, 0);
        @(posedge clk);
        #1;
        check("rel_ready_high", {31'd0, bus.ready_out}, 1);
        rdy_mode = 0;
        bus.ready_in = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.data_in  = '0;
        bus.sop_in   = 1'b0;
        bus.eop_in   = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        #2;
        do_reset();

        // Directed luma values and two-cycle latency at the start of a frame.
        n_out = 0;
        send_beat(24'hFFFFFF, 1'b1, 1'b0);
        check("lat_not_yet", {31'd0, bus.valid_out}, 0);
        step();
        check("lat_valid", {31'd0, bus.valid_out}, 1);
        check("luma_ffffff", {24'd0, bus.data_out}, 32'hFF);
        check("sop_first", {31'd0, bus.sop_out}, 1);
        send_beat(24'h000000, 1'b0, 1'b0);
        step();
        check("luma_000000", {24'd0, bus.data_out}, 32'h00);
        send_beat(24'hFF0000, 1'b0, 1'b0);
        step();
        check("luma_ff0000", {24'd0, bus.data_out}, {24'd0, luma(24'hFF0000)});
        check("no_sop_mid", {31'd0, bus.sop_out}, 0);
        send_pixels(3, NPIX - 1, NPIX - 1);
        drain();
        check("frame1_outputs", n_out, NPIX);
        check_counters("frame1", 1'b0, 16'd1);

        // Random valid gaps and 50% ready_in.
        gap_en   = 1'b1;
        rdy_mode = 1;
        send_pixels(0, NPIX - 1, NPIX - 1);
        send_pixels(0, NPIX - 1, NPIX - 1);
        drain();
        gap_en = 1'b0;
        check_counters("random", 1'b0, 16'd3);

        // Downstream stall mid-frame: pipe fills, ready_out drops, order kept.
        send_pixels(0, 4, NPIX - 1);
        drain();
        rdy_mode     = 2;
        bus.ready_in = 1'b0;
        send_pixels(5, 6, NPIX - 1);
        check("stall_ready_low", {31'd0, bus.ready_out}, 0);
        repeat (10) step();
        check("stall_still_low", {30'd0, bus.ready_out, bus.valid_out}, 32'd1);
        rdy_mode = 0;
        send_pixels(7, NPIX - 1, NPIX - 1);
        drain();
        check_counters("stall", 1'b0, 16'd4);

        // Early eop, then a clean frame: error stays sticky.
        send_pixels(0, 10, 10);
        drain();
        check_counters("early_eop", 1'b1, 16'd5);
        send_pixels(0, NPIX - 1, NPIX - 1);
        drain();
        check_counters("after_err", 1'b1, 16'd6);

        // Reset with both stages full.
        send_pixels(0, 5, NPIX - 1);
        drain();
        rdy_mode     = 2;
        bus.ready_in = 1'b0;
        send_pixels(6, 7, NPIX - 1);
        check("full_before_rst", {30'd0, bus.ready_out, bus.valid_out}, 32'd1);
        do_reset();
        send_pixels(0, NPIX - 1, NPIX - 1);
        drain();
        check_counters("post_reset", 1'b0, 16'd1);

        // One-pixel frame.
        send_beat(24'($urandom), 1'b1, 1'b1);
        drain();
        check_counters("one_pixel", 1'b1, 16'd2);

        // Data without a preceding sop.
        do_reset();
        send_beat(24'($urandom), 1'b0, 1'b0);
        drain();
        check_counters("no_sop", 1'b1, 16'd0);

        // Second sop inside a frame.
        do_reset();
        send_pixels(0, 3, NPIX - 1);
        send_beat(24'($urandom), 1'b1, 1'b0);
        drain();
        check_counters("dup_sop", 1'b1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
